i2c_eeprom_byte_ctrl: RTL

I2C_EEPROM_BYTE_CTRL -- requirements
Module: i2c_eeprom_byte_ctrl

---
 rtl/i2c_eeprom_byte_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_eeprom_byte_ctrl.sv
// I2C slave front end for a byte-addressed EEPROM: matches the device address,
// delivers word address / write bytes as strobes and serialises read bytes onto SDA.
module i2c_eeprom_byte_ctrl #(
  parameter logic [6:0] DEV_ADDR = 7'b1010000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       addr_load,
  output logic [7:0] addr_o,
  output logic       addr_inc,
  output logic [7:0] wdata_o,
  output logic       wr_stb,
  input  logic [7:0] rdata_i,
  output logic       rd_stb,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, WADDR, WADDR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       oe_q, oe_d;
  logic       phase_q, phase_d;
  logic       rw_q, rw_d;
  logic       load_q, load_d, inc_q, inc_d, wr_q, wr_d, rd_q, rd_d;
  logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, load_rd;
  logic [7:0] byte_in;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign byte_in   = {sh_q[6:0], sda_s};

  assign sda_oe    = oe_q;
  assign addr_load = load_q;
  assign addr_inc  = inc_q;
  assign wr_stb    = wr_q;
  assign rd_stb    = rd_q;
  assign addr_o    = addr_q;
  assign wdata_o   = wdata_q;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      oe_q       <= 1'b0;
      phase_q    <= 1'b0;
      rw_q       <= 1'b0;
      load_q     <= 1'b0;
      inc_q      <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      oe_q       <= oe_d;
      phase_q    <= phase_d;
      rw_q       <= rw_d;
      load_q     <= load_d;
      inc_q      <= inc_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end

  // ACK states use oe_q as their phase: first SCL fall asserts, second releases.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    oe_d    = oe_q;
    phase_d = phase_q;
    rw_d    = rw_q;
    load_d  = 1'b0;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    inc_d   = wr_q;
    load_rd = 1'b0;
    if (stop_det) begin
      state_d = IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      phase_d = 1'b0;
    end else if (start_det) begin
      state_d = DEV;
      cnt_d   = '0;
      oe_d    = 1'b0;
      phase_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        DEV, WADDR, WDATA: begin
          if (scl_rise) begin
            sh_d  = byte_in;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (state_q == DEV) begin
                rw_d    = byte_in[0];
                state_d = (byte_in[7:1] == DEV_ADDR) ? DEV_ACK : WAIT_STOP;
              end else if (state_q == WADDR) begin
                addr_d  = byte_in;
                load_d  = 1'b1;
                state_d = WADDR_ACK;
              end else begin
                wdata_d = byte_in;
                wr_d    = 1'b1;
                state_d = WDATA_ACK;
              end
            end
          end
        end
        DEV_ACK, WADDR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d = 1'b0;
              if (state_q == DEV_ACK && rw_q) load_rd = 1'b1;
              else if (state_q == DEV_ACK)    state_d = WADDR;
              else                            state_d = WDATA;
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) phase_d = 1'b1;
          end else if (scl_fall) begin
            if (phase_q) begin
              oe_d    = 1'b0;
              phase_d = 1'b0;
              state_d = RACK;
            end else begin
              oe_d = ~sh_q[7];
              sh_d = {sh_q[6:0], 1'b0};
            end
          end
        end
        RACK: begin
          if (scl_rise) begin
            inc_d = 1'b1;
            if (sda_s) state_d = WAIT_STOP;
            else       phase_d = 1'b1;
          end else if (scl_fall && phase_q) begin
            load_rd = 1'b1;
          end
        end
        WAIT_STOP: oe_d = 1'b0;
        default:   state_d = IDLE;
      endcase
    end
    if (load_rd) begin
      sh_d    = {rdata_i[6:0], 1'b0};
      oe_d    = ~rdata_i[7];
      rd_d    = 1'b1;
      phase_d = 1'b0;
      cnt_d   = '0;
      state_d = RDATA;
    end
  end

endmodule
